button_conditioner: RTL

Per-button debouncer and event generator for the alarm-clock front panel. It consumes the already-synchronised button levels from the two-flop DFF synchroniser stage and emits clean levels plus single-cycle press, release and auto-repeat pulses. The time-set, alarm-set and mode control logic consume these pulses. Each button channel is independent; all state is in the `clk` domain.

---
 rtl/button_conditioner_if.sv | 27 ++
 rtl/button_conditioner.sv | 108 ++++++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
// Button bus between the synchroniser stage and the conditioner: raw levels in,
// debounced level and event pulses out.
interface button_conditioner_if #(
  parameter int unsigned N_BTN = 5
);
  logic [N_BTN-1:0] btn_sync;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output btn_sync,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_sync,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel debouncer with registered press/release pulses and a hold/auto-repeat FSM.
// Channels are fully independent; all outputs come straight from flops.
module button_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave btn
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RptMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;

  localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] HoldLast = RptW'(HOLD_CYCLES - 1);
  localparam logic [RptW-1:0] RptLast  = RptW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  logic [N_BTN-1:0] level_vec;
  logic [N_BTN-1:0] press_vec;
  logic [N_BTN-1:0] release_vec;
  logic [N_BTN-1:0] repeat_vec;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            level_q, level_d;
    logic            press_q, release_q, repeat_q, repeat_d;
    logic            differ, accept, rise, fall;
    state_e          state_q, state_d;

    // Level toggles on the edge where the counter is at its last value and the
    // input still disagrees; any agreement restarts the count.
    always_comb begin
      differ   = btn.btn_sync[i] ^ level_q;
      accept   = differ && (db_cnt_q == DbLast);
      rise     = accept && !level_q;
      fall     = accept && level_q;
      level_d  = level_q ^ accept;
      db_cnt_d = (!differ || accept) ? '0 : db_cnt_q + 1'b1;
    end

    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      repeat_d  = 1'b0;
      unique case (state_q)
        StIdle: begin
          rpt_cnt_d = '0;
          if (rise) state_d = StHold;
        end
        StHold, StRepeat: begin
          // A release on the terminal-count edge suppresses the repeat pulse.
          if (fall) begin
            state_d   = StIdle;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == ((state_q == StHold) ? HoldLast : RptLast)) begin
            repeat_d  = 1'b1;
            rpt_cnt_d = '0;
            state_d   = StRepeat;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = StIdle;
          rpt_cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt_q  <= '0;
        rpt_cnt_q <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        state_q   <= StIdle;
      end else begin
        db_cnt_q  <= db_cnt_d;
        rpt_cnt_q <= rpt_cnt_d;
        level_q   <= level_d;
        press_q   <= rise;
        release_q <= fall;
        repeat_q  <= repeat_d;
        state_q   <= state_d;
      end
    end

    assign level_vec[i]   = level_q;
    assign press_vec[i]   = press_q;
    assign release_vec[i] = release_q;
    assign repeat_vec[i]  = repeat_q;
  end

  assign btn.btn_level   = level_vec;
  assign btn.btn_press   = press_vec;
  assign btn.btn_release = release_vec;
  assign btn.btn_repeat  = repeat_vec;

endmodule
